// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares one single-port data memory between two masters: m0 (CPU
//   load/store port) and m1 (DMA / peripheral loader). One access is
//   granted per cycle. When both masters request, the master that owned
//   the previous cycle keeps the memory until it has had MAX_BURST
//   consecutive grants, then the other master gets it. Coming out of an
//   idle cycle, the master that did not own the memory last goes first.
//   Accesses to the 0x4xxxxxxx region still use up the grant slot, but
//   they never touch the memory and they return an error response.
//
// Ports
//   clk, reset            clock; asynchronous active-low reset
//   mX_req/wr/addr/wdata  request from master X (held stable until granted)
//   mX_gnt                combinational grant for the current cycle
//   mX_rvalid/rdata/err   registered response, one cycle after mX_gnt
//   mem_rd/wr/addr/wdata  memory strobes and bus, driven in the grant cycle
//   mem_rdata             combinational read data from the memory
//   owner                 00 none, 01 m0, 10 m1 (current-cycle grant)
//
// Parameters
//   RAM_SIZE_BIT  word-address bits the memory decodes (mem_addr[RAM_SIZE_BIT+1:2]);
//                 the arbiter always forwards the full 32-bit address
//   MAX_BURST     consecutive grants one master may take while the other waits (1..15)

module dmem_arbiter #(
  parameter int RAM_SIZE_BIT = 8,
  parameter int MAX_BURST    = 4
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        m0_req,
  input  logic        m0_wr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic        m0_err,

  input  logic        m1_req,
  input  logic        m1_wr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        m1_err,

  output logic        mem_rd,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,

  output logic [1:0]  owner
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  localparam logic [3:0] BurstLimit = 4'(MAX_BURST);
  localparam logic [3:0] BurstSat   = 4'hF;

  // Stop elaboration when a parameter is outside the range this design handles.
  if (MAX_BURST < 1 || MAX_BURST > 15 || RAM_SIZE_BIT < 1 || RAM_SIZE_BIT > 30) begin : gBadParams
    $error("dmem_arbiter: MAX_BURST or RAM_SIZE_BIT out of range");
  end

  // Arbitration state
  state_e      state_q, state_d;
  logic [3:0]  burstCnt_q, burstCnt_d;
  logic        idleFavM1_q, idleFavM1_d;

  // Grant and selected-request signals
  logic        underLimit;
  logic        favM1;
  logic        gnt0, gnt1, granted;
  logic        selWr;
  logic [31:0] selAddr, selWdata;
  logic        forbidden;

  // Response registers, one set per master
  logic        rvalid0_q, rvalid0_d;
  logic        err0_q, err0_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic        rvalid1_q, rvalid1_d;
  logic        err1_q, err1_d;
  logic [31:0] rdata1_q, rdata1_d;

  assign underLimit = (burstCnt_q < BurstLimit);

  // Pick the favoured master for the contended case. The current owner keeps
  // the memory while it is under the burst limit. After an idle cycle the
  // favoured master is the one that did not own the memory last.
  always_comb begin
    favM1 = idleFavM1_q;
    case (state_q)
      OWN0:    favM1 = ~underLimit;
      OWN1:    favM1 = underLimit;
      default: favM1 = idleFavM1_q;
    endcase

    if (m0_req && m1_req) begin
      gnt0 = ~favM1;
      gnt1 = favM1;
    end else begin
      gnt0 = m0_req;
      gnt1 = m1_req;
    end
  end

  // Next arbitration state. A repeat grant to the current owner extends its
  // burst (saturating). A grant to the other master starts a new burst of
  // one. A cycle with no grant returns to IDLE and remembers who to favour.
  always_comb begin
    state_d     = state_q;
    burstCnt_d  = burstCnt_q;
    idleFavM1_d = idleFavM1_q;

    if (gnt0) begin
      if (state_q == OWN0) begin
        if (burstCnt_q != BurstSat) begin
          burstCnt_d = burstCnt_q + 4'd1;
        end
      end else begin
        state_d    = OWN0;
        burstCnt_d = 4'd1;
      end
      idleFavM1_d = 1'b1;
    end else if (gnt1) begin
      if (state_q == OWN1) begin
        if (burstCnt_q != BurstSat) begin
          burstCnt_d = burstCnt_q + 4'd1;
        end
      end else begin
        state_d    = OWN1;
        burstCnt_d = 4'd1;
      end
      idleFavM1_d = 1'b0;
    end else begin
      state_d    = IDLE;
      burstCnt_d = 4'd0;
    end
  end

  // Route the granted master onto the memory bus. The bus idles at zero, and
  // a forbidden access drives no strobe.
  always_comb begin
    selWr    = 1'b0;
    selAddr  = 32'd0;
    selWdata = 32'd0;
    if (gnt0) begin
      selWr    = m0_wr;
      selAddr  = m0_addr;
      selWdata = m0_wdata;
    end else if (gnt1) begin
      selWr    = m1_wr;
      selAddr  = m1_addr;
      selWdata = m1_wdata;
    end

    granted   = gnt0 | gnt1;
    forbidden = granted && (selAddr[31:28] == 4'h4);

    mem_addr  = selAddr;
    mem_wdata = selWdata;
    mem_rd    = granted & ~selWr & ~forbidden;
    mem_wr    = granted &  selWr & ~forbidden;
    owner     = {gnt1, gnt0};
  end

  assign m0_gnt = gnt0;
  assign m1_gnt = gnt1;

  // Response for the master granted this cycle. Read data is captured only
  // for real reads. Writes and blocked accesses return zero. A master that
  // was not granted keeps its last read data.
  always_comb begin
    rvalid0_d = gnt0;
    err0_d    = gnt0 & forbidden;
    rdata0_d  = rdata0_q;
    if (gnt0) begin
      rdata0_d = mem_rd ? mem_rdata : 32'd0;
    end

    rvalid1_d = gnt1;
    err1_d    = gnt1 & forbidden;
    rdata1_d  = rdata1_q;
    if (gnt1) begin
      rdata1_d = mem_rd ? mem_rdata : 32'd0;
    end
  end

  // Arbitration state registers. After reset m0 is favoured.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      burstCnt_q  <= 4'd0;
      idleFavM1_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      burstCnt_q  <= burstCnt_d;
      idleFavM1_q <= idleFavM1_d;
    end
  end

  // Response registers. A response still pending when reset asserts is dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rvalid0_q <= 1'b0;
      err0_q    <= 1'b0;
      rdata0_q  <= 32'd0;
      rvalid1_q <= 1'b0;
      err1_q    <= 1'b0;
      rdata1_q  <= 32'd0;
    end else begin
      rvalid0_q <= rvalid0_d;
      err0_q    <= err0_d;
      rdata0_q  <= rdata0_d;
      rvalid1_q <= rvalid1_d;
      err1_q    <= err1_d;
      rdata1_q  <= rdata1_d;
    end
  end

  assign m0_rvalid = rvalid0_q;
  assign m0_err    = err0_q;
  assign m0_rdata  = rdata0_q;
  assign m1_rvalid = rvalid1_q;
  assign m1_err    = err1_q;
  assign m1_rdata  = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
//   Testbench for dmem_arbiter. A small word-addressed RAM sits on the
//   memory side. A reference model predicts each cycle's grant from the
//   grant history and predicts each response from its own copy of the
//   memory contents. Expected responses go into per-master queues, and a
//   separate monitor compares them against mX_rvalid/rdata/err.

module tb_dmem_arbiter;

  localparam int RAM_SIZE_BIT = 8;
  localparam int MAX_BURST    = 4;
  localparam int RandCycles   = 2000;

  typedef struct {
    int          due;
    logic [31:0] rdata;
    logic        err;
  } respT;

  logic        clk;
  logic        reset;
  logic        m0_req, m0_wr, m0_gnt, m0_rvalid, m0_err;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic        m1_req, m1_wr, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic        mem_rd, mem_wr;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  owner;

  int          vecCount;
  int          missCount;
  int          cycNum;

  // Reference model state
  int          hist[$];
  logic [31:0] refMem[int];
  respT        q0[$];
  respT        q1[$];
  logic [31:0] lastRd0, lastRd1;
  logic        mGnt0, mGnt1;

  // Memory seen by the arbiter
  logic [31:0] ram[0:(1<<RAM_SIZE_BIT)-1];
  logic        ramClear;

  dmem_arbiter #(
    .RAM_SIZE_BIT(RAM_SIZE_BIT),
    .MAX_BURST   (MAX_BURST)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .m0_req   (m0_req),
    .m0_wr    (m0_wr),
    .m0_addr  (m0_addr),
    .m0_wdata (m0_wdata),
    .m0_gnt   (m0_gnt),
    .m0_rvalid(m0_rvalid),
    .m0_rdata (m0_rdata),
    .m0_err   (m0_err),
    .m1_req   (m1_req),
    .m1_wr    (m1_wr),
    .m1_addr  (m1_addr),
    .m1_wdata (m1_wdata),
    .m1_gnt   (m1_gnt),
    .m1_rvalid(m1_rvalid),
    .m1_rdata (m1_rdata),
    .m1_err   (m1_err),
    .mem_rd   (mem_rd),
    .mem_wr   (mem_wr),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .owner    (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational read and clocked write, like the real data memory
  assign mem_rdata = ram[mem_addr[RAM_SIZE_BIT+1:2]];

  always @(posedge clk) begin
    if (ramClear) begin
      for (int i = 0; i < (1<<RAM_SIZE_BIT); i++) ram[i] <= 32'd0;
    end else if (mem_wr) begin
      ram[mem_addr[RAM_SIZE_BIT+1:2]] <= mem_wdata;
    end
  end

  initial cycNum = 0;
  always @(posedge clk) cycNum <= cycNum + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vecCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Grant prediction from the list of past grants (-1 = idle cycle).
  function automatic int predictGrant(input logic r0, input logic r1);
    int prev, last, run, idx;
    if (!r0 && !r1) return -1;
    if (r0 && !r1) return 0;
    if (!r0 && r1) return 1;
    prev = (hist.size() == 0) ? -1 : hist[hist.size()-1];
    if (prev == -1) begin
      last = -1;
      idx  = hist.size() - 1;
      while (idx >= 0 && last == -1) begin
        last = hist[idx];
        idx--;
      end
      return (last == 0) ? 1 : 0;
    end
    run = 0;
    idx = hist.size() - 1;
    while (idx >= 0 && hist[idx] == prev) begin
      run++;
      idx--;
    end
    return (run < MAX_BURST) ? prev : 1 - prev;
  endfunction

  task automatic flushModel();
    hist.delete();
    q0.delete();
    q1.delete();
    lastRd0 = 32'd0;
    lastRd1 = 32'd0;
    mGnt0   = 1'b0;
    mGnt1   = 1'b0;
  endtask

  // Per-cycle check of the grant and memory side, plus scoreboard push
  task automatic checkCycle();
    int          g, idx;
    logic        w, forb;
    logic [31:0] a, d;
    respT        r;
    g = predictGrant(m0_req, m1_req);
    w = 1'b0;
    a = 32'd0;
    d = 32'd0;
    if (g == 0) begin w = m0_wr; a = m0_addr; d = m0_wdata; end
    if (g == 1) begin w = m1_wr; a = m1_addr; d = m1_wdata; end
    forb = (g >= 0) && (a[31:28] == 4'h4);
    checkOutput("m0_gnt", 32'(m0_gnt), 32'(g == 0));
    checkOutput("m1_gnt", 32'(m1_gnt), 32'(g == 1));
    checkOutput("owner", 32'(owner), (g == 0) ? 32'd1 : (g == 1) ? 32'd2 : 32'd0);
    checkOutput("mem_rd", 32'(mem_rd), 32'((g >= 0) && !w && !forb));
    checkOutput("mem_wr", 32'(mem_wr), 32'((g >= 0) && w && !forb));
    checkOutput("mem_addr", mem_addr, a);
    checkOutput("mem_wdata", mem_wdata, d);
    hist.push_back(g);
    mGnt0 = (g == 0);
    mGnt1 = (g == 1);
    if (g >= 0) begin
      idx     = int'(a[RAM_SIZE_BIT+1:2]);
      r.due   = cycNum + 1;
      r.err   = forb;
      r.rdata = 32'd0;
      if (!forb) begin
        if (w) refMem[idx] = d;
        else r.rdata = refMem.exists(idx) ? refMem[idx] : 32'd0;
      end
      if (g == 0) q0.push_back(r);
      else q1.push_back(r);
    end
  endtask

  function automatic int qSize(input int m);
    return (m == 0) ? q0.size() : q1.size();
  endfunction

  function automatic int qFrontDue(input int m);
    return (m == 0) ? q0[0].due : q1[0].due;
  endfunction

  function automatic respT qPop(input int m);
    if (m == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  task automatic monitorPort(input int m, input logic rv, input logic [31:0] rd, input logic er);
    respT        e;
    logic [31:0] lastRd;
    lastRd = (m == 0) ? lastRd0 : lastRd1;
    if (rv === 1'b1) begin
      if (qSize(m) == 0) begin
        checkOutput($sformatf("m%0d_rvalid unexpected", m), 32'(rv), 32'd0);
      end else begin
        e = qPop(m);
        checkOutput($sformatf("m%0d_rvalid cycle", m), cycNum, e.due);
        checkOutput($sformatf("m%0d_rdata", m), rd, e.rdata);
        checkOutput($sformatf("m%0d_err", m), 32'(er), 32'(e.err));
        if (m == 0) lastRd0 = e.rdata;
        else lastRd1 = e.rdata;
      end
    end else begin
      checkOutput($sformatf("m%0d_err idle", m), 32'(er), 32'd0);
      checkOutput($sformatf("m%0d_rdata hold", m), rd, lastRd);
      if (qSize(m) != 0 && qFrontDue(m) <= cycNum) begin
        e = qPop(m);
        checkOutput($sformatf("m%0d_rvalid missing", m), 32'(rv), 32'd1);
      end
    end
  endtask

  // Request-side checker
  initial begin
    forever begin
      @(negedge clk);
      if (reset === 1'b1) checkCycle();
    end
  end

  // Response monitor
  initial begin
    forever begin
      @(negedge clk);
      if (reset === 1'b1) begin
        monitorPort(0, m0_rvalid, m0_rdata, m0_err);
        monitorPort(1, m1_rvalid, m1_rdata, m1_err);
      end
    end
  end

  task automatic applyStimulus(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                               input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1);
    @(posedge clk);
    #1;
    m0_req = r0; m0_wr = w0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_wr = w1; m1_addr = a1; m1_wdata = d1;
  endtask

  task automatic applyIdle();
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic sampleNeg();
    @(negedge clk);
    #1;
  endtask

  task automatic checkResetOutputs();
    checkOutput("rst m0_gnt", 32'(m0_gnt), 32'd0);
    checkOutput("rst m1_gnt", 32'(m1_gnt), 32'd0);
    checkOutput("rst m0_rvalid", 32'(m0_rvalid), 32'd0);
    checkOutput("rst m1_rvalid", 32'(m1_rvalid), 32'd0);
    checkOutput("rst m0_err", 32'(m0_err), 32'd0);
    checkOutput("rst m1_err", 32'(m1_err), 32'd0);
    checkOutput("rst m0_rdata", m0_rdata, 32'd0);
    checkOutput("rst m1_rdata", m1_rdata, 32'd0);
    checkOutput("rst mem_rd", 32'(mem_rd), 32'd0);
    checkOutput("rst mem_wr", 32'(mem_wr), 32'd0);
    checkOutput("rst owner", 32'(owner), 32'd0);
  endtask

  task automatic holdReset(input int cycles);
    @(posedge clk);
    #1;
    reset = 1'b0;
    m0_req = 1'b0;
    m1_req = 1'b0;
    flushModel();
    repeat (cycles) @(posedge clk);
    #1;
    checkResetOutputs();
    reset = 1'b1;
  endtask

  function automatic logic [31:0] randAddr();
    logic [31:0] a;
    a       = $urandom;
    a[1:0]  = 2'b00;
    a[RAM_SIZE_BIT+1:2] = RAM_SIZE_BIT'($urandom_range(0, 15));
    case ($urandom_range(0, 7))
      0:       a[31:28] = 4'h4;
      1:       a[31:28] = 4'h1;
      2:       a[31:28] = 4'hF;
      default: a[31:28] = 4'h0;
    endcase
    return a;
  endfunction

  int burstExp[10] = '{1, 1, 1, 1, 2, 2, 2, 2, 1, 1};

  initial begin
    vecCount  = 0;
    missCount = 0;
    reset     = 1'b0;
    ramClear  = 1'b1;
    m0_req = 1'b0; m0_wr = 1'b0; m0_addr = 32'd0; m0_wdata = 32'd0;
    m1_req = 1'b0; m1_wr = 1'b0; m1_addr = 32'd0; m1_wdata = 32'd0;
    flushModel();

    // Power-on reset
    repeat (3) @(posedge clk);
    #1;
    checkResetOutputs();
    ramClear = 1'b0;
    reset    = 1'b1;

    // Single master write then read
    applyStimulus(1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'd0, 32'd0);
    sampleNeg();
    checkOutput("sm wr m0_gnt", 32'(m0_gnt), 32'd1);
    checkOutput("sm wr mem_wr", 32'(mem_wr), 32'd1);
    applyStimulus(1'b1, 1'b0, 32'h0000_0010, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    sampleNeg();
    checkOutput("sm rd m0_gnt", 32'(m0_gnt), 32'd1);
    checkOutput("sm rd mem_rd", 32'(mem_rd), 32'd1);
    applyIdle();
    sampleNeg();
    checkOutput("sm m0_rvalid", 32'(m0_rvalid), 32'd1);
    checkOutput("sm m0_rdata", m0_rdata, 32'hDEAD_BEEF);
    checkOutput("sm m0_err", 32'(m0_err), 32'd0);

    // Forbidden region
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'h4000_0004, 32'd0);
    sampleNeg();
    checkOutput("fb m1_gnt", 32'(m1_gnt), 32'd1);
    checkOutput("fb mem_rd", 32'(mem_rd), 32'd0);
    checkOutput("fb mem_wr", 32'(mem_wr), 32'd0);
    applyIdle();
    sampleNeg();
    checkOutput("fb m1_rvalid", 32'(m1_rvalid), 32'd1);
    checkOutput("fb m1_err", 32'(m1_err), 32'd1);
    checkOutput("fb m1_rdata", m1_rdata, 32'd0);

    // Cross-master coherency
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678);
    applyStimulus(1'b1, 1'b0, 32'h0000_0020, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    applyIdle();
    sampleNeg();
    checkOutput("coh m0_rvalid", 32'(m0_rvalid), 32'd1);
    checkOutput("coh m0_rdata", m0_rdata, 32'h1234_5678);

    // Idle gap: m1 goes first after m0 owned the memory
    applyStimulus(1'b1, 1'b0, 32'h0000_0020, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h0000_0024, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    applyIdle();
    applyStimulus(1'b1, 1'b0, 32'h0000_0030, 32'd0, 1'b1, 1'b0, 32'h0000_0034, 32'd0);
    sampleNeg();
    checkOutput("gap m1_gnt", 32'(m1_gnt), 32'd1);
    checkOutput("gap owner", 32'(owner), 32'd2);
    applyIdle();

    // Burst lock from reset, both masters streaming
    holdReset(2);
    applyStimulus(1'b1, 1'b0, 32'h0000_0010, 32'd0, 1'b1, 1'b0, 32'h0000_0020, 32'd0);
    for (int i = 0; i < 10; i++) begin
      sampleNeg();
      checkOutput($sformatf("burst owner %0d", i), 32'(owner), 32'(burstExp[i]));
    end
    applyIdle();

    // Reset pulsed between the grant and its response
    applyStimulus(1'b1, 1'b0, 32'h0000_0010, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    #1;
    reset  = 1'b0;
    m0_req = 1'b0;
    m1_req = 1'b0;
    flushModel();
    #1;
    checkResetOutputs();
    #1;
    reset = 1'b1;
    sampleNeg();
    checkOutput("rst-pulse m0_rvalid", 32'(m0_rvalid), 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h0000_0010, 32'd0, 1'b1, 1'b0, 32'h0000_0020, 32'd0);
    sampleNeg();
    checkOutput("rst-pulse owner", 32'(owner), 32'd1);
    applyIdle();

    // Randomised traffic: hold each request until the model says it was granted
    for (int c = 0; c < RandCycles; c++) begin
      @(posedge clk);
      #1;
      if (!m0_req || mGnt0) begin
        m0_req   = ($urandom_range(0, 3) != 0);
        m0_wr    = 1'($urandom_range(0, 1));
        m0_addr  = randAddr();
        m0_wdata = $urandom;
      end else if ($urandom_range(0, 15) == 0) begin
        m0_req = 1'b0;
      end
      if (!m1_req || mGnt1) begin
        m1_req   = ($urandom_range(0, 3) != 0);
        m1_wr    = 1'($urandom_range(0, 1));
        m1_addr  = randAddr();
        m1_wdata = $urandom;
      end else if ($urandom_range(0, 15) == 0) begin
        m1_req = 1'b0;
      end
    end

    applyIdle();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("m0 responses outstanding", 32'(q0.size()), 32'd0);
    checkOutput("m1 responses outstanding", 32'(q1.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
